// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the iterative M-extension multiply/divide unit:
// funct3 encodings, FSM states, decoder constants and signedness helpers.
package ex_muldiv_pkg;

  localparam logic [2:0] MULDIV_MUL    = 3'd0;
  localparam logic [2:0] MULDIV_MULH   = 3'd1;
  localparam logic [2:0] MULDIV_MULHSU = 3'd2;
  localparam logic [2:0] MULDIV_MULHU  = 3'd3;
  localparam logic [2:0] MULDIV_DIV    = 3'd4;
  localparam logic [2:0] MULDIV_DIVU   = 3'd5;
  localparam logic [2:0] MULDIV_REM    = 3'd6;
  localparam logic [2:0] MULDIV_REMU   = 3'd7;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_32  = 7'b0111011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic op1_signed(input logic [2:0] op);
    return op inside {MULDIV_MUL, MULDIV_MULH, MULDIV_MULHSU, MULDIV_DIV, MULDIV_REM};
  endfunction

  function automatic logic op2_signed(input logic [2:0] op);
    return op inside {MULDIV_MUL, MULDIV_MULH, MULDIV_DIV, MULDIV_REM};
  endfunction

endpackage

// File: rtl/ex_muldiv_iter.sv
// Radix-2 magnitude datapath: one shift-add (multiply) or restoring
// subtract (divide) step per cycle on a {hi, lo} register pair.
module muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            div,
  input  logic [XLEN-1:0] load_lo,
  input  logic [XLEN-1:0] load_mag,
  output logic [XLEN-1:0] hi_nxt,
  output logic [XLEN-1:0] lo_nxt
);

  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;
  logic [XLEN-1:0] mag_q;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;
  logic            fits;

  // Multiply: lo holds the multiplier and drains out the bottom while the
  // product grows in from the top. Divide: lo holds the dividend and fills
  // with quotient bits from the bottom; hi is the partial remainder.
  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_q} : '0);
    shifted = {hi_q, lo_q[XLEN-1]};
    fits    = shifted >= {1'b0, mag_q};
    diff    = shifted[XLEN-1:0] - mag_q;
    if (div) begin
      hi_nxt = fits ? diff : shifted[XLEN-1:0];
      lo_nxt = {lo_q[XLEN-2:0], fits};
    end else begin
      hi_nxt = sum[XLEN:1];
      lo_nxt = {sum[0], lo_q[XLEN-1:1]};
    end
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q  <= '0;
      lo_q  <= '0;
      mag_q <= '0;
    end else if (load) begin
      hi_q  <= '0;
      lo_q  <= load_lo;
      mag_q <= load_mag;
    end else if (step) begin
      hi_q  <= hi_nxt;
      lo_q  <= lo_nxt;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M/RV64M execution unit: FSM, iteration counter, sign
// handling, special-case shortcuts and the hold/write-back handshake.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [4:0]      rd_addr2ex,
  input  logic            flush,
  output logic            hold2ctrl,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] rd_data,
  output logic            rd_wen2reg
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state_q, state_nxt;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        op_q;
  logic [4:0]        addr_q;
  logic              neg_q, rem_neg_q, done_q;
  logic [4:0]        rd_addr_q;
  logic [XLEN-1:0]   rd_data_q;

  logic              sign1, sign2, div_zero, overflow, special, accept, last_step;
  logic [XLEN-1:0]   mag1, mag2, special_res, calc_res;
  logic [XLEN-1:0]   hi_nxt, lo_nxt, quo_fix, rem_fix;
  logic [2*XLEN-1:0] prod, prod_fix;

  assign sign1     = op1[XLEN-1] & op1_signed(op);
  assign sign2     = op2[XLEN-1] & op2_signed(op);
  assign mag1      = sign1 ? -op1 : op1;
  assign mag2      = sign2 ? -op2 : op2;
  assign div_zero  = is_div(op) && (op2 == '0);
  assign overflow  = (op == MULDIV_DIV || op == MULDIV_REM) && (op1 == MIN_NEG) && (op2 == '1);
  assign special   = div_zero | overflow;
  assign accept    = (state_q == IDLE) && start && !flush;
  assign last_step = (state_q == CALC) && (cnt_q == '0);

  muldiv_iter #(.XLEN(XLEN)) u_iter (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .step     (state_q == CALC),
    .div      (op_q[2]),
    .load_lo  (is_div(op) ? mag1 : mag2),
    .load_mag (is_div(op) ? mag2 : mag1),
    .hi_nxt   (hi_nxt),
    .lo_nxt   (lo_nxt)
  );

  // NOTE: defaults first so no path through the block leaves a latch.
  always_comb begin
    special_res = '0;
    if (div_zero)      special_res = (op == MULDIV_DIV || op == MULDIV_DIVU) ? '1 : op1;
    else if (overflow) special_res = (op == MULDIV_DIV) ? op1 : '0;
  end

  // Sign correction uses the value the final step is about to produce.
  always_comb begin
    prod     = {hi_nxt, lo_nxt};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -lo_nxt : lo_nxt;
    rem_fix  = rem_neg_q ? -hi_nxt : hi_nxt;
    case (op_q)
      MULDIV_MUL:                                 calc_res = prod_fix[XLEN-1:0];
      MULDIV_MULH, MULDIV_MULHSU, MULDIV_MULHU:   calc_res = prod_fix[2*XLEN-1:XLEN];
      MULDIV_DIV, MULDIV_DIVU:                    calc_res = quo_fix;
      default:                                    calc_res = rem_fix;
    endcase
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (accept) state_nxt = special ? DONE : CALC;
      CALC:    if (flush) state_nxt = IDLE;
               else if (cnt_q == '0) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      op_q      <= '0;
      addr_q    <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      done_q    <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      if (accept) begin
        cnt_q     <= CNT_W'(XLEN - 1);
        op_q      <= op;
        addr_q    <= rd_addr2ex;
        neg_q     <= sign1 ^ sign2;
        rem_neg_q <= sign1;
      end else if (state_q == CALC && cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      done_q <= (state_nxt == DONE);
      if (accept && special) begin
        rd_addr_q <= rd_addr2ex;
        rd_data_q <= special_res;
      end else if (last_step && !flush) begin
        rd_addr_q <= addr_q;
        rd_data_q <= calc_res;
      end
    end
  end

  // A flush arriving in the write-back cycle still suppresses the write.
  assign rd_wen2reg = done_q & ~flush;
  assign hold2ctrl  = ((state_q == IDLE) && start) || (state_q == CALC);
  assign rd_addr    = rd_addr_q;
  assign rd_data    = rd_data_q;

endmodule
